muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide execution unit; successor to the fixed 8-bit datapath multiplier.
//  Sits beside the ALU and is gated onto the CPU bus by the datapath.
//  Supports signed/unsigned full-width multiply (double-width product) and signed/unsigned divide
//  (quotient + remainder), one result bit per clock, with a Run/Ready handshake.
// PARAMETERS
//  WIDTH   16   operand/result width in bits; legal range 2..32
// PORTS
//  Clk      in   1      system clock; all state updates on rising edge
//  Reset    in   1      synchronous, active-high reset
//  Run      in   1      start request; sampled only in IDLE
//  Fn       in   2      00 MULU, 01 MULS, 10 DIVU, 11 DIVS; sampled with Run
//  A        in   WIDTH  multiplicand / dividend; sampled with Run
//  B        in   WIDTH  multiplier / divisor; sampled with Run
//  Out      out  WIDTH  product low half / quotient
//  OutHi    out  WIDTH  product high half / remainder
//  Ready    out  1      1 = idle, Out/OutHi valid for last operation
//  DivZero  out  1      1 = last operation was a divide with B == 0
// BEHAVIOUR
//  Reset: state=IDLE, Out=0, OutHi=0, Ready=1, DivZero=0; overrides everything, including mid-operation.
//  States: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: Ready=1. Edge with Run=1 latches Fn, |A|/|B| (signed fns) or A/B; count=WIDTH; goto CALC.
//   CALC: exactly WIDTH edges. MUL: shift-add, 2*WIDTH accumulator. DIV: restoring shift-subtract.
//         Ready=0; Run, A, B, Fn ignored.
//   FIX: one edge. Applies sign fixup and writes Out/OutHi/DivZero; goto IDLE.
//  Latency: Run sampled at edge 0 -> Ready=1 and results valid after edge WIDTH+1.
//  Out/OutHi/DivZero change only at the FIX edge; they hold the previous result during CALC.
//  Run held high in IDLE starts back-to-back operations. There is no idle gap beyond the IDLE cycle.
//  MULU/MULS: {OutHi,Out} = full 2*WIDTH product. The low half is identical for both; the high half is sign-correct for MULS.
//  MULS sign: product negated in FIX iff A[MSB]^B[MSB].
//  DIVU: Out = A/B, OutHi = A%B.
//  DIVS: truncates toward zero. Quotient negated iff signs differ; remainder takes the dividend's sign.
//  Signed overflow MIN/-1: Out = MIN, OutHi = 0, DivZero = 0 (two's-complement wrap; no trap).
//  B == 0 on divide: full latency still taken. Out = all ones, OutHi = A (original, unmodified), DivZero = 1.
//  B == 0 on multiply: ordinary zero result, DivZero = 0.
//  DivZero is cleared at the FIX edge of any non-faulting operation.
//  All arithmetic is modulo 2^WIDTH per half; the internal accumulator is 2*WIDTH+1 bits (one carry/borrow bit).
// STRUCTURE
//  Package elc3_pkg additions:
//   - typedef enum logic [1:0] muldiv_fn_t {MULU, MULS, DIVU, DIVS}
//   - typedef enum logic [1:0] muldiv_state_t {MD_IDLE, MD_CALC, MD_FIX}
//  Single module; the counter, sign flags and accumulator are local registers. No sub-module.
//  The datapath drives Run from the MUL_EN control signal, uses Ready as MUL_R, and gates Out onto the bus (OutHi via a second gate).
// TESTING (WIDTH=16 unless noted)
//  MULU A=FFFF B=FFFF -> after edge 17: Out=0001, OutHi=FFFE, Ready=1; Ready=0 on edges 1..16.
//  MULS A=FFFD(-3) B=0005 -> Out=FFF1, OutHi=FFFF.
//  DIVS A=FFF9(-7) B=0002 -> Out=FFFD, OutHi=FFFF.
//  DIVS A=8000 B=FFFF -> Out=8000, OutHi=0000, DivZero=0.
//  DIVU A=0064 B=0000 -> Out=FFFF, OutHi=0064, DivZero=1; a following MULU 2*3 -> Out=0006, DivZero=0.
//  Run+MULU 3*3, change A/B/Fn and pulse Run during CALC -> result 0009 unaffected.
//   Then Reset at edge 5 of a new op -> Ready=1, Out=0, OutHi=0 after that edge.
//  WIDTH=4 sweep: exhaustive A,B over all four Fn vs a reference model; latency = 5 edges.

Source files
------------

// File: rtl/elc3_pkg.sv
// Shared types for the ELC3 execution units: multiply/divide function codes and FSM states.
package elc3_pkg;

    typedef enum logic [1:0] {
        MULU = 2'b00,
        MULS = 2'b01,
        DIVU = 2'b10,
        DIVS = 2'b11
    } muldiv_fn_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } muldiv_state_t;

    function automatic logic fn_is_div(input muldiv_fn_t f);
        return f[1];
    endfunction

    function automatic logic fn_is_signed(input muldiv_fn_t f);
        return f[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Run/Ready bus between the datapath and the multiply/divide unit.
interface muldiv_unit_if
    import elc3_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             Run;
    muldiv_fn_t       Fn;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Out;
    logic [WIDTH-1:0] OutHi;
    logic             Ready;
    logic             DivZero;

    modport master (output Run, Fn, A, B, input Out, OutHi, Ready, DivZero);
    modport slave  (input Run, Fn, A, B, output Out, OutHi, Ready, DivZero);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: one result bit per clock on unsigned magnitudes, sign fixup in FIX.
// Latency WIDTH+2 edges from Run to Ready; Run is ignored while busy, results hold until the FIX edge.
module muldiv_unit
    import elc3_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH + 1;

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    muldiv_fn_t       fn_q, fn_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             bz_q, bz_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] outhi_q, outhi_d;
    logic             dz_q, dz_d;

    logic             sgn;
    logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
    logic [WIDTH:0]   sum, sh_hi;
    logic [AW-1:0]    sh;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            fn_q    <= MULU;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            bz_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            outhi_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fn_q    <= fn_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            bz_q    <= bz_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            outhi_q <= outhi_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fn_d    = fn_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        bz_d    = bz_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        outhi_d = outhi_q;
        dz_d    = dz_q;
        sgn     = fn_is_signed(bus.Fn);
        a_mag   = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        b_mag   = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
        sum     = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, b_q} : '0);
        sh      = {acc_q[AW-2:0], 1'b0};
        sh_hi   = sh[AW-1:WIDTH];
        prod    = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        quo     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem     = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            MD_IDLE: begin
                if (bus.Run) begin
                    fn_d    = bus.Fn;
                    neg_d   = sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    rneg_d  = (bus.Fn == DIVS) & bus.A[WIDTH-1];
                    bz_d    = (bus.B == '0);
                    a_d     = bus.A;
                    b_d     = b_mag;
                    acc_d   = {{(WIDTH+1){1'b0}}, a_mag};
                    cnt_d   = CW'(WIDTH);
                    state_d = MD_CALC;
                end
            end
            MD_CALC: begin
                // Multiply shifts right adding into the top half; divide shifts left, quotient bits enter at bit 0.
                if (fn_is_div(fn_q)) begin
                    if (sh_hi >= {1'b0, b_q}) begin
                        acc_d = {sh_hi - {1'b0, b_q}, sh[WIDTH-1:1], 1'b1};
                    end else begin
                        acc_d = sh;
                    end
                end else begin
                    acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                if (!fn_is_div(fn_q)) begin
                    out_d   = prod[WIDTH-1:0];
                    outhi_d = prod[2*WIDTH-1:WIDTH];
                    dz_d    = 1'b0;
                end else if (bz_q) begin
                    out_d   = '1;
                    outhi_d = a_q;
                    dz_d    = 1'b1;
                end else begin
                    out_d   = quo;
                    outhi_d = rem;
                    dz_d    = 1'b0;
                end
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign bus.Ready   = (state_q == MD_IDLE);
    assign bus.Out     = out_q;
    assign bus.OutHi   = outhi_q;
    assign bus.DivZero = dz_q;

endmodule
